// File: rtl/tlb_pkg.sv
// tlb_pkg: shared types and constants for the TLB and its page-table walker.
// Holds the walker state encoding, the PTE field layout and the address widths
// that the cache and the walker must agree on.
package tlb_pkg;

    localparam int VA_W   = 64;
    localparam int PA_W   = 64;
    localparam int PCID_W = 12;

    localparam int PAGE_SHIFT = 12;
    localparam int IDX_W      = 9;
    localparam int PTE_V      = 0;
    localparam int PTE_LEAF   = 1;
    localparam int PPN_HI     = 51;

    localparam int LVL_W  = 2;
    // Table base / physical frame number as carried between levels (PA bits 63:12).
    localparam int BASE_W = PA_W - PAGE_SHIFT;
    // PPN field width inside a PTE (bits 51:12).
    localparam int PPN_W  = PPN_HI - PAGE_SHIFT + 1;
    // VA bits 47:12 that feed the four 9-bit table indices.
    localparam int VPN_W  = 4 * IDX_W;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_FILL = 3'd3,
        ST_FLT  = 3'd4
    } ptw_state_t;

    // PTE layout, MSB first: reserved[63:52], ppn[51:12], software[11:2], leaf[1], v[0].
    typedef struct packed {
        logic [11:0]      rsvd;
        logic [PPN_W-1:0] ppn;
        logic [9:0]       sw;
        logic             leaf;
        logic             v;
    } pte_t;

    // A 48-bit canonical VA has bits 63:48 equal to copies of bit 47.
    function automatic logic is_canonical(input logic [VA_W-1:0] addr);
        return addr[63:48] == {16{addr[47]}};
    endfunction

endpackage

// File: rtl/ptw_idx_sel.sv
// ptw_idx_sel: picks the 9-bit table index for a walk level out of VA[47:12]
// and forms the 8-byte aligned PTE address {base, index, 3'b000}.
module ptw_idx_sel
    import tlb_pkg::*;
(
    input  logic [VPN_W-1:0]  vpn,
    input  logic [BASE_W-1:0] base,
    input  logic [LVL_W-1:0]  lvl,
    output logic [PA_W-1:0]   addr
);

    logic [IDX_W-1:0] idx;

    // Level 3 is the root and uses the top index field; level 0 the lowest.
    always_comb begin
        case (lvl)
            2'd0:    idx = vpn[8:0];
            2'd1:    idx = vpn[17:9];
            2'd2:    idx = vpn[26:18];
            default: idx = vpn[35:27];
        endcase
        addr = {base, idx, 3'b000};
    end

endmodule

// File: rtl/tlb_ptw.sv
// tlb_ptw: 4-level page-table walker servicing TLB misses.
// Latches the missing VA/PCID, reads one PTE per level over a simple
// req/gnt + rvalid read port, then either fills the TLB or raises a fault.
// Memory port: a request is offered with mem_req/mem_addr held stable until
// mem_gnt is seen high at a clock edge; the single response is the cycle in
// which mem_rvalid is high, and it is only consumed while waiting for it.
// Optional build macro TLB_PTW_HUGE_PAGE_EN: allows 2 MiB (level 1) and
// 1 GiB (level 2) leaf entries; without it any leaf above level 0 faults.
module tlb_ptw
    import tlb_pkg::*;
(
    input  logic              clk,
    input  logic              shutdown,
    input  logic              miss,
    input  logic [VA_W-1:0]   miss_va,
    input  logic [PCID_W-1:0] miss_pcid,
    input  logic [PA_W-1:0]   root_base,
    output logic              busy,
    output logic              mem_req,
    output logic [PA_W-1:0]   mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [63:0]       mem_rdata,
    output logic              insert,
    output logic [VA_W-1:0]   va,
    output logic [PA_W-1:0]   pa,
    output logic [PCID_W-1:0] pcid,
    output logic              fault,
    output logic [LVL_W-1:0]  fault_lvl
);

    ptw_state_t         state;
    logic [LVL_W-1:0]   lvl;
    logic [BASE_W-1:0]  base_q;
    logic [VA_W-13:0]   vpn_q;
    logic [PCID_W-1:0]  pcid_q;

    pte_t               pte;
    logic [VPN_W-1:0]   sel_vpn;
    logic [BASE_W-1:0]  sel_base;
    logic [LVL_W-1:0]   sel_lvl;
    logic [PA_W-1:0]    sel_addr;
    logic               leaf_ok;
    logic [PA_W-1:0]    leaf_pa;
    logic               unused_bits;

    assign pte = pte_t'(mem_rdata);

    // Page offsets, root_base low bits and PTE reserved/software fields play no part.
    assign unused_bits = ^{root_base[11:0], miss_va[11:0], pte.rsvd, pte.sw};

    // Operands for the next PTE address: a fresh miss in IDLE, the next level in WAIT.
    always_comb begin
        sel_vpn  = vpn_q[VPN_W-1:0];
        sel_base = base_q;
        sel_lvl  = lvl;
        if (state == ST_IDLE) begin
            sel_vpn  = miss_va[47:12];
            sel_base = root_base[63:12];
            sel_lvl  = 2'd3;
        end else if (state == ST_WAIT) begin
            sel_base = {{(BASE_W-PPN_W){1'b0}}, pte.ppn};
            sel_lvl  = lvl - 2'd1;
        end
    end

    ptw_idx_sel u_idx_sel (
        .vpn  (sel_vpn),
        .base (sel_base),
        .lvl  (sel_lvl),
        .addr (sel_addr)
    );

`ifdef TLB_PTW_HUGE_PAGE_EN
    // Leaf decode with huge pages: frame bits below the page size must be clear.
    always_comb begin
        leaf_ok = 1'b0;
        leaf_pa = {12'h000, pte.ppn, 12'h000};
        case (lvl)
            2'd0: begin
                leaf_ok = 1'b1;
            end
            2'd1: begin
                leaf_ok = (pte.ppn[8:0] == 9'd0);
                leaf_pa = {12'h000, pte.ppn[39:9], vpn_q[8:0], 12'h000};
            end
            2'd2: begin
                leaf_ok = (pte.ppn[17:0] == 18'd0);
                leaf_pa = {12'h000, pte.ppn[39:18], vpn_q[17:0], 12'h000};
            end
            default: begin
                leaf_ok = 1'b0;
            end
        endcase
    end
`else
    // Leaf decode with 4 KiB pages only: a leaf is legal solely at level 0.
    always_comb begin
        leaf_ok = (lvl == 2'd0);
        leaf_pa = {12'h000, pte.ppn, 12'h000};
    end
`endif

    // Walker FSM; every output is registered and set on the transition into its state.
    always_ff @(posedge clk) begin
        if (shutdown) begin
            state     <= ST_IDLE;
            lvl       <= '0;
            base_q    <= '0;
            vpn_q     <= '0;
            pcid_q    <= '0;
            busy      <= 1'b0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            insert    <= 1'b0;
            fault     <= 1'b0;
            fault_lvl <= '0;
            va        <= '0;
            pa        <= '0;
            pcid      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (miss) begin
                        vpn_q  <= miss_va[63:12];
                        pcid_q <= miss_pcid;
                        base_q <= root_base[63:12];
                        lvl    <= 2'd3;
                        busy   <= 1'b1;
                        if (!is_canonical(miss_va)) begin
                            fault     <= 1'b1;
                            fault_lvl <= 2'd3;
                            state     <= ST_FLT;
                        end else begin
                            mem_req  <= 1'b1;
                            mem_addr <= sel_addr;
                            state    <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        if (!pte.v) begin
                            fault     <= 1'b1;
                            fault_lvl <= lvl;
                            state     <= ST_FLT;
                        end else if (pte.leaf) begin
                            if (leaf_ok) begin
                                insert <= 1'b1;
                                va     <= {vpn_q, 12'h000};
                                pa     <= leaf_pa;
                                pcid   <= pcid_q;
                                state  <= ST_FILL;
                            end else begin
                                fault     <= 1'b1;
                                fault_lvl <= lvl;
                                state     <= ST_FLT;
                            end
                        end else if (lvl == 2'd0) begin
                            fault     <= 1'b1;
                            fault_lvl <= lvl;
                            state     <= ST_FLT;
                        end else begin
                            base_q   <= sel_base;
                            lvl      <= sel_lvl;
                            mem_req  <= 1'b1;
                            mem_addr <= sel_addr;
                            state    <= ST_REQ;
                        end
                    end
                end
                ST_FILL: begin
                    insert <= 1'b0;
                    busy   <= 1'b0;
                    state  <= ST_IDLE;
                end
                ST_FLT: begin
                    fault <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    mem_req <= 1'b0;
                    insert  <= 1'b0;
                    fault   <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tlb_ptw.sv
// tb_tlb_ptw: directed bench for the page-table walker. A scripted memory
// responder answers each PTE read; counters on the falling edge tally
// handshakes, fills and faults per scenario.
module tb_tlb_ptw;

    logic        clk = 1'b0;
    logic        shutdown;
    logic        miss;
    logic [63:0] miss_va;
    logic [11:0] miss_pcid;
    logic [63:0] root_base;
    logic        busy;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        insert;
    logic [63:0] va;
    logic [63:0] pa;
    logic [11:0] pcid;
    logic        fault;
    logic [1:0]  fault_lvl;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t_miss   = 0;
    int n_hs     = 0;
    int n_ins    = 0;
    int n_flt    = 0;

    // clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tlb_ptw dut (
        .clk        (clk),
        .shutdown   (shutdown),
        .miss       (miss),
        .miss_va    (miss_va),
        .miss_pcid  (miss_pcid),
        .root_base  (root_base),
        .busy       (busy),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .insert     (insert),
        .va         (va),
        .pa         (pa),
        .pcid       (pcid),
        .fault      (fault),
        .fault_lvl  (fault_lvl)
    );

    // event tallies, sampled mid-cycle
    always @(negedge clk) begin
        if (mem_req && mem_gnt) n_hs++;
        if (insert) n_ins++;
        if (fault) n_flt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        n_hs  = 0;
        n_ins = 0;
        n_flt = 0;
    endtask

    task automatic send_miss(input logic [63:0] a, input logic [11:0] p, input logic [63:0] rb);
        miss      = 1'b1;
        miss_va   = a;
        miss_pcid = p;
        root_base = rb;
        tick();
        miss   = 1'b0;
        t_miss = cyc;
    endtask

    // Wait (bounded) for a request, check its address, optionally stall, then grant.
    task automatic req_phase(input string tag, input logic [63:0] exp_addr, input int hold, input bit inject);
        int waited = 0;
        while (!mem_req && waited < 20) begin
            tick();
            waited++;
        end
        check_eq({tag, "_req"}, {63'd0, mem_req}, 64'd1);
        check_eq({tag, "_addr"}, mem_addr, exp_addr);
        for (int i = 0; i < hold; i++) begin
            if (inject && i == 0) begin
                miss      = 1'b1;
                miss_va   = 64'h0000_0000_0000_5000;
                miss_pcid = 12'h007;
            end
            tick();
            miss = 1'b0;
            check_eq({tag, "_hold_addr"}, mem_addr, exp_addr);
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
    endtask

    task automatic data_phase(input logic [63:0] pte);
        mem_rvalid = 1'b1;
        mem_rdata  = pte;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
    endtask

    initial begin
        shutdown   = 1'b1;
        miss       = 1'b0;
        miss_va    = '0;
        miss_pcid  = '0;
        root_base  = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        tick();
        tick();
        shutdown = 1'b0;

        // reset state
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_mem_req", {63'd0, mem_req}, 64'd0);
        check_eq("rst_insert", {63'd0, insert}, 64'd0);
        check_eq("rst_fault", {63'd0, fault}, 64'd0);
        check_eq("rst_mem_addr", mem_addr, 64'd0);
        check_eq("rst_pa", pa, 64'd0);

        // clean 4-level walk
        clear_counts();
        send_miss(64'h0000_7FFF_FFFF_F123, 12'h001, 64'h1000);
        check_eq("w1_busy", {63'd0, busy}, 64'd1);
        req_phase("w1_l3", 64'h17F8, 0, 1'b0);
        data_phase(64'h2001);
        req_phase("w1_l2", 64'h2FF8, 0, 1'b0);
        data_phase(64'h3001);
        req_phase("w1_l1", 64'h3FF8, 0, 1'b0);
        data_phase(64'h4001);
        req_phase("w1_l0", 64'h4FF8, 0, 1'b0);
        data_phase(64'hABCD_E003);
        check_eq("w1_insert", {63'd0, insert}, 64'd1);
        check_eq("w1_va", va, 64'h7FFF_FFFF_F000);
        check_eq("w1_pa", pa, 64'hABCD_E000);
        check_eq("w1_pcid", {52'd0, pcid}, 64'd1);
        check_eq("w1_latency", 64'(cyc - t_miss + 1), 64'd9);
        tick();
        check_eq("w1_insert_drop", {63'd0, insert}, 64'd0);
        check_eq("w1_busy_drop", {63'd0, busy}, 64'd0);
        check_eq("w1_va_hold", va, 64'h7FFF_FFFF_F000);
        check_eq("w1_handshakes", 64'(n_hs), 64'd4);
        check_eq("w1_inserts", 64'(n_ins), 64'd1);
        check_eq("w1_faults", 64'(n_flt), 64'd0);

        // invalid PTE at level 1
        clear_counts();
        send_miss(64'h0000_0000_0040_3000, 12'h002, 64'h5000);
        req_phase("w2_l3", 64'h5000, 0, 1'b0);
        data_phase(64'h6001);
        req_phase("w2_l2", 64'h6000, 0, 1'b0);
        data_phase(64'h7001);
        req_phase("w2_l1", 64'h7010, 0, 1'b0);
        data_phase(64'h0);
        check_eq("w2_fault", {63'd0, fault}, 64'd1);
        check_eq("w2_fault_lvl", {62'd0, fault_lvl}, 64'd1);
        check_eq("w2_insert", {63'd0, insert}, 64'd0);
        tick();
        check_eq("w2_fault_drop", {63'd0, fault}, 64'd0);
        check_eq("w2_busy_drop", {63'd0, busy}, 64'd0);
        check_eq("w2_inserts", 64'(n_ins), 64'd0);
        check_eq("w2_faults", 64'(n_flt), 64'd1);
        check_eq("w2_va_hold", va, 64'h7FFF_FFFF_F000);

        // non-canonical VA
        clear_counts();
        send_miss(64'h0001_0000_0000_0000, 12'h003, 64'h1000);
        check_eq("w3_fault", {63'd0, fault}, 64'd1);
        check_eq("w3_fault_lvl", {62'd0, fault_lvl}, 64'd3);
        check_eq("w3_mem_req", {63'd0, mem_req}, 64'd0);
        tick();
        tick();
        check_eq("w3_busy", {63'd0, busy}, 64'd0);
        check_eq("w3_handshakes", 64'(n_hs), 64'd0);
        check_eq("w3_inserts", 64'(n_ins), 64'd0);

        // grant stall with a second miss during the walk
        clear_counts();
        send_miss(64'h0000_7FFF_FFFF_F123, 12'h001, 64'h1000);
        req_phase("w4_l3", 64'h17F8, 5, 1'b1);
        data_phase(64'h2001);
        req_phase("w4_l2", 64'h2FF8, 0, 1'b0);
        data_phase(64'h3001);
        req_phase("w4_l1", 64'h3FF8, 0, 1'b0);
        data_phase(64'h4001);
        req_phase("w4_l0", 64'h4FF8, 0, 1'b0);
        data_phase(64'hABCD_E003);
        check_eq("w4_insert", {63'd0, insert}, 64'd1);
        check_eq("w4_va", va, 64'h7FFF_FFFF_F000);
        check_eq("w4_pcid", {52'd0, pcid}, 64'd1);
        check_eq("w4_latency", 64'(cyc - t_miss + 1), 64'd14);
        tick();
        tick();
        tick();
        check_eq("w4_busy", {63'd0, busy}, 64'd0);
        check_eq("w4_handshakes", 64'(n_hs), 64'd4);
        check_eq("w4_inserts", 64'(n_ins), 64'd1);

        // shutdown while waiting for data, then a stale response
        clear_counts();
        send_miss(64'h0, 12'h009, 64'h9000);
        req_phase("w5_l3", 64'h9000, 0, 1'b0);
        shutdown = 1'b1;
        tick();
        shutdown = 1'b0;
        check_eq("w5_busy", {63'd0, busy}, 64'd0);
        check_eq("w5_mem_req", {63'd0, mem_req}, 64'd0);
        check_eq("w5_mem_addr", mem_addr, 64'd0);
        check_eq("w5_va", va, 64'd0);
        check_eq("w5_pa", pa, 64'd0);
        check_eq("w5_pcid", {52'd0, pcid}, 64'd0);
        check_eq("w5_fault_lvl", {62'd0, fault_lvl}, 64'd0);
        data_phase(64'hABCD_E003);
        tick();
        tick();
        check_eq("w5_stale_ins", 64'(n_ins), 64'd0);
        check_eq("w5_stale_flt", 64'(n_flt), 64'd0);
        check_eq("w5_stale_busy", {63'd0, busy}, 64'd0);
        send_miss(64'h0000_0000_0040_3000, 12'h005, 64'h5000);
        req_phase("w5b_l3", 64'h5000, 0, 1'b0);
        data_phase(64'h6001);
        req_phase("w5b_l2", 64'h6000, 0, 1'b0);
        data_phase(64'h7001);
        req_phase("w5b_l1", 64'h7010, 0, 1'b0);
        data_phase(64'h8001);
        req_phase("w5b_l0", 64'h8018, 0, 1'b0);
        data_phase(64'h1234_5003);
        check_eq("w5b_insert", {63'd0, insert}, 64'd1);
        check_eq("w5b_va", va, 64'h40_3000);
        check_eq("w5b_pa", pa, 64'h1234_5000);
        check_eq("w5b_pcid", {52'd0, pcid}, 64'd5);
        tick();

        // shutdown together with miss: reset wins
        clear_counts();
        shutdown  = 1'b1;
        miss      = 1'b1;
        miss_va   = 64'h0000_0000_0000_1000;
        root_base = 64'h1000;
        tick();
        shutdown = 1'b0;
        miss     = 1'b0;
        check_eq("w6_busy", {63'd0, busy}, 64'd0);
        check_eq("w6_mem_req", {63'd0, mem_req}, 64'd0);
        tick();
        check_eq("w6_handshakes", 64'(n_hs), 64'd0);

        // leaf at level 1 (2 MiB page when enabled)
        clear_counts();
        send_miss(64'h1234_5000, 12'h004, 64'h1000);
        req_phase("w7_l3", 64'h1000, 0, 1'b0);
        data_phase(64'h2001);
        req_phase("w7_l2", 64'h2000, 0, 1'b0);
        data_phase(64'h3001);
        req_phase("w7_l1", 64'h3488, 0, 1'b0);
        data_phase(64'h8020_0003);
`ifdef TLB_PTW_HUGE_PAGE_EN
        check_eq("w7_insert", {63'd0, insert}, 64'd1);
        check_eq("w7_pa", pa, 64'h8034_5000);
        check_eq("w7_va", va, 64'h1234_5000);
        check_eq("w7_pcid", {52'd0, pcid}, 64'd4);
`else
        check_eq("w7_fault", {63'd0, fault}, 64'd1);
        check_eq("w7_fault_lvl", {62'd0, fault_lvl}, 64'd1);
        check_eq("w7_insert", {63'd0, insert}, 64'd0);
`endif
        tick();
        check_eq("w7_busy", {63'd0, busy}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
